ledwalker_wb: RTL and testbench
===============================

# ledwalker_wb

Parametrised, bus-controlled LED walker. Sweeps one lit LED across `NLEDS` outputs in bounce or wrap mode. Step period, pass count and abort are all software-controlled. A Wishbone (pipelined, single-cycle ack, never stalls) slave sits between the bus interconnect and the board LED pins. One walk request can be queued behind the walk in progress, and a completion pulse is produced for an interrupt controller.

## Interface
- `NLEDS`, 8 — number of LEDs; legal range 2..32.
- `CW`, 26 — step-divider width in bits.
- `DEFAULT_DIV`, 49_999_999 — reset value of the divider register (clocks per step minus 1); must fit in `CW` bits.

- `i_clk` — input, 1 — single system clock.
- `i_reset` — input, 1 — asynchronous, active-high reset.
- `i_wb_cyc`, `i_wb_stb`, `i_wb_we` — input, 1 each — Wishbone cycle, strobe and write enable.
- `i_wb_addr` — input, 2 — register select.
- `i_wb_data` — input, 32 — write data.
- `o_wb_stall` — output, 1 — tied 0.
- `o_wb_ack` — output, 1 — request acknowledge.
- `o_wb_data` — output, 32 — read data.
- `o_led` — output, `NLEDS` — one-hot while busy, all-zero while idle.
- `o_busy` — output, 1 — walk in progress.
- `o_done` — output, 1 — one-cycle pulse when a walk completes naturally.

## Operation
- Accepted request: `i_wb_cyc & i_wb_stb`. Every accepted request is acked, reads and writes alike.
- Registers:
  - addr 0 CTRL (write): bit 0 = mode (0 bounce, 1 wrap); bits 15:8 = pass count, where 0 means repeat until abort.
  - addr 1 DIV (read/write): low `CW` bits; upper bits are ignored on write and read back as 0.
  - addr 2 ABORT (write, data ignored).
  - addr 3 STATUS (read only): bit 0 busy, bit 1 pending, bit 2 mode, bits 15:8 passes remaining, bits 20:16 LED position.
  - Reads of addr 0 and addr 2 return 0. Writes to addr 3 are ignored.
- Pass sequence:
  - Bounce: positions 0,1,…,N-1,…,1,0, giving 2N-1 steps.
  - Wrap: positions 0..N-1, giving N steps.
  - Consecutive passes are concatenated, so position 0 repeats at each boundary.
- CTRL write while idle: walk starts at position 0 with the written mode and pass count.
- CTRL write while busy: the request is stored as pending. A later CTRL write overwrites the pending request.
- At natural completion:
  - If a request is pending, it starts on the next cycle at position 0. No idle cycle, no `o_done` pulse.
  - Otherwise the block goes idle and `o_done` pulses.
- ABORT: the walk and any pending request clear immediately. No `o_done` pulse. ABORT while idle has no effect.
- DIV write: takes effect at the next step-timer reload, never mid-step.
- Simultaneous events in one cycle are impossible (one bus request per cycle). If a CTRL write lands on the final step of the last pass, it starts the new walk directly.
- State machine:
  - IDLE → RUN on a CTRL write.
  - RUN → RUN on a step, or on pass wrap when passes remain or a request is pending.
  - RUN → IDLE on completion or abort.

## Timing
- Reset values: `o_led`=0, `o_busy`=0, `o_done`=0, `o_wb_ack`=0, `o_wb_data`=0, DIV=`DEFAULT_DIV`, pending=0.
- A request at cycle t is acked at t+1. Read data is valid at t+1.
- `o_led` and `o_busy` are registered. After a CTRL write accepted at t (idle), `o_led`=1 and `o_busy`=1 at t+1.
- Each position is held exactly DIV+1 clocks. A walk of P passes stays busy for P·steps·(DIV+1) clocks.
- `o_done` is asserted in the first cycle `o_busy` is 0 after completion.
- Reset asserted mid-walk: all outputs clear asynchronously, and the block returns to IDLE with pending cleared.

## Structure
- Shared package `ledwalker_pkg`:
  - register address constants (`ADDR_CTRL`, `ADDR_DIV`, `ADDR_ABORT`, `ADDR_STATUS`);
  - mode constants (`MODE_BOUNCE`, `MODE_WRAP`);
  - STATUS and CTRL field bit positions.
- Sub-module `ledwalker_step_timer`:
  - `CW`-bit down-counter; loads DIV on start and on each step.
  - Emits a one-cycle step strobe when the count reaches 0.
  - Inputs: clock, reset, run, div. Output: step.
- Top level holds the bus decode, position/direction/pass registers, the pending latch and the LED decode.

## Test plan
- **Single bounce:** NLEDS=4, DIV=2, CTRL=0x0100 → `o_led` goes 1,2,4,8,4,2,1, each for 3 clocks; busy for 21 clocks; one `o_done` pulse.
- **Wrap, 2 passes:** CTRL=0x0201 → `o_led` goes 1,2,4,8,1,2,4,8; busy for 24 clocks.
- **Queued request:** CTRL bounce×1 issued, then CTRL=0x0101 while busy → STATUS pending=1; the wrap pass follows with no idle gap; exactly one `o_done` pulse, at the end.
- **Infinite walk, then abort:** CTRL=0x0000 runs beyond 100 clocks; ABORT → `o_led`=0 and busy=0 on the next cycle; no `o_done`.
- **DIV change mid-step:** write DIV=5 during a DIV=2 step → the current step still lasts 3 clocks, the next lasts 6; DIV reads back 5.
- **Reset mid-walk:** assert `i_reset` asynchronously → all outputs 0 immediately; DIV returns to `DEFAULT_DIV`; every ack arrives exactly 1 cycle after its request.

Source files
------------

// File: rtl/ledwalker_pkg.sv
// Shared constants and types for the Wishbone-controlled LED walker.
package ledwalker_pkg;

    localparam int unsigned WB_AW = 2;
    localparam int unsigned WB_DW = 32;

    localparam logic [WB_AW-1:0] ADDR_CTRL   = 2'd0;
    localparam logic [WB_AW-1:0] ADDR_DIV    = 2'd1;
    localparam logic [WB_AW-1:0] ADDR_ABORT  = 2'd2;
    localparam logic [WB_AW-1:0] ADDR_STATUS = 2'd3;

    localparam logic MODE_BOUNCE = 1'b0;
    localparam logic MODE_WRAP   = 1'b1;

    localparam int unsigned PASS_W        = 8;
    localparam int unsigned CTRL_MODE_BIT = 0;
    localparam int unsigned CTRL_PASS_LSB = 8;

    localparam int unsigned STAT_BUSY_BIT = 0;
    localparam int unsigned STAT_PEND_BIT = 1;
    localparam int unsigned STAT_MODE_BIT = 2;
    localparam int unsigned STAT_PASS_LSB = 8;
    localparam int unsigned STAT_POS_LSB  = 16;
    localparam int unsigned STAT_POS_W    = 5;

    // Walk request as written through CTRL
    typedef struct packed {
        logic [PASS_W-1:0] passes;
        logic              mode;
    } walk_req_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/ledwalker_wb_if.sv
// Wishbone pipelined slave bus bundle; signal names are from the slave's view.
interface ledwalker_wb_if;
    import ledwalker_pkg::*;

    logic             i_wb_cyc;
    logic             i_wb_stb;
    logic             i_wb_we;
    logic [WB_AW-1:0] i_wb_addr;
    logic [WB_DW-1:0] i_wb_data;
    logic             o_wb_stall;
    logic             o_wb_ack;
    logic [WB_DW-1:0] o_wb_data;

    modport slave (
        input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data,
        output o_wb_stall, o_wb_ack, o_wb_data
    );

    modport master (
        output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data,
        input  o_wb_stall, o_wb_ack, o_wb_data
    );

endinterface

// File: rtl/ledwalker_step_timer.sv
// Step divider: each position lasts div+1 clocks; div is sampled only at reload.
module ledwalker_step_timer #(
    parameter int unsigned CW = 26
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_run,
    input  logic [CW-1:0] i_div,
    output logic          o_step_c
);

    logic [CW-1:0] r_count;

    // Preload while stopped, reload on every step, otherwise count down
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (!i_run || (r_count == '0)) begin
            r_count <= i_div;
        end else begin
            r_count <= r_count - CW'(1);
        end
    end

    assign o_step_c = i_run && (r_count == '0);

endmodule

// File: rtl/ledwalker_wb.sv
// LED walker with Wishbone register file, one-deep request queue and done pulse.
module ledwalker_wb
    import ledwalker_pkg::*;
#(
    parameter int unsigned NLEDS       = 8,
    parameter int unsigned CW          = 26,
    parameter int unsigned DEFAULT_DIV = 49_999_999
) (
    input  logic             i_clk,
    input  logic             i_reset,
    ledwalker_wb_if.slave    io_wb,
    output logic [NLEDS-1:0] o_led,
    output logic             o_busy,
    output logic             o_done
);

    localparam int unsigned PW = $clog2(NLEDS);
    localparam logic [PW-1:0] LAST_POS = PW'(NLEDS - 1);

    state_t            r_state;
    logic [PW-1:0]     r_pos;
    logic              r_dir;
    walk_req_t         r_req;
    logic              r_pend;
    walk_req_t         r_pend_req;
    logic [CW-1:0]     r_div;
    logic [NLEDS-1:0]  r_led;
    logic              r_busy;
    logic              r_done;
    logic              r_ack;
    logic [WB_DW-1:0]  r_rdata;

    state_t            w_state_nxt;
    logic [PW-1:0]     w_pos_nxt;
    logic              w_dir_nxt;
    walk_req_t         w_req_nxt;
    logic              w_pend_nxt;
    walk_req_t         w_pend_req_nxt;
    logic              w_done_nxt;
    logic [NLEDS-1:0]  w_led_nxt;
    logic              w_start;
    walk_req_t         w_start_req;

    logic              w_req;
    logic              w_wr_ctrl;
    logic              w_wr_div;
    logic              w_abort;
    walk_req_t         w_ctrl_req;
    logic              w_step;
    logic              w_pass_end;
    logic [WB_DW-1:0]  w_status;
    logic [WB_DW-1:0]  w_rdata;
    logic              w_unused;

    // Bus decode
    assign w_req     = io_wb.i_wb_cyc && io_wb.i_wb_stb;
    assign w_wr_ctrl = w_req && io_wb.i_wb_we && (io_wb.i_wb_addr == ADDR_CTRL);
    assign w_wr_div  = w_req && io_wb.i_wb_we && (io_wb.i_wb_addr == ADDR_DIV);
    assign w_abort   = w_req && io_wb.i_wb_we && (io_wb.i_wb_addr == ADDR_ABORT);
    assign w_ctrl_req.mode   = io_wb.i_wb_data[CTRL_MODE_BIT];
    assign w_ctrl_req.passes = io_wb.i_wb_data[CTRL_PASS_LSB +: PASS_W];
    assign w_unused  = &{1'b0, io_wb.i_wb_data};

    ledwalker_step_timer #(
        .CW (CW)
    ) u_timer (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_run    (r_busy),
        .i_div    (r_div),
        .o_step_c (w_step)
    );

    // Last step of a pass: wrap ends at the top, bounce ends back at 0 heading down
    assign w_pass_end = (r_req.mode == MODE_BOUNCE) ? (r_dir && (r_pos == '0))
                                                    : (r_pos == LAST_POS);

    // State register and walk datapath
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_pos      <= '0;
            r_dir      <= 1'b0;
            r_req      <= '0;
            r_pend     <= 1'b0;
            r_pend_req <= '0;
            r_led      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pos      <= w_pos_nxt;
            r_dir      <= w_dir_nxt;
            r_req      <= w_req_nxt;
            r_pend     <= w_pend_nxt;
            r_pend_req <= w_pend_req_nxt;
            r_led      <= w_led_nxt;
            r_busy     <= (w_state_nxt == S_RUN);
            r_done     <= w_done_nxt;
        end
    end

    // Next-state: start, queue, step, pass wrap, completion and abort
    always_comb begin
        w_state_nxt    = r_state;
        w_pos_nxt      = r_pos;
        w_dir_nxt      = r_dir;
        w_req_nxt      = r_req;
        w_pend_nxt     = r_pend;
        w_pend_req_nxt = r_pend_req;
        w_done_nxt     = 1'b0;
        w_start        = 1'b0;
        w_start_req    = w_ctrl_req;

        case (r_state)
            S_IDLE: begin
                if (w_wr_ctrl) begin
                    w_start = 1'b1;
                end
            end
            S_RUN: begin
                if (w_wr_ctrl) begin
                    w_pend_nxt     = 1'b1;
                    w_pend_req_nxt = w_ctrl_req;
                end
                if (w_abort) begin
                    w_state_nxt      = S_IDLE;
                    w_pos_nxt        = '0;
                    w_dir_nxt        = 1'b0;
                    w_req_nxt.passes = '0;
                    w_pend_nxt       = 1'b0;
                end else if (w_step) begin
                    if (w_pass_end) begin
                        if (r_req.passes == PASS_W'(1)) begin
                            if (w_wr_ctrl) begin
                                w_start    = 1'b1;
                                w_pend_nxt = 1'b0;
                            end else if (r_pend) begin
                                w_start     = 1'b1;
                                w_start_req = r_pend_req;
                                w_pend_nxt  = 1'b0;
                            end else begin
                                w_state_nxt      = S_IDLE;
                                w_pos_nxt        = '0;
                                w_dir_nxt        = 1'b0;
                                w_req_nxt.passes = '0;
                                w_done_nxt       = 1'b1;
                            end
                        end else begin
                            w_pos_nxt = '0;
                            w_dir_nxt = 1'b0;
                            if (r_req.passes != '0) begin
                                w_req_nxt.passes = r_req.passes - PASS_W'(1);
                            end
                        end
                    end else if (r_req.mode == MODE_WRAP) begin
                        w_pos_nxt = r_pos + PW'(1);
                    end else if (!r_dir) begin
                        if (r_pos == LAST_POS) begin
                            w_pos_nxt = r_pos - PW'(1);
                            w_dir_nxt = 1'b1;
                        end else begin
                            w_pos_nxt = r_pos + PW'(1);
                        end
                    end else begin
                        w_pos_nxt = r_pos - PW'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_start) begin
            w_state_nxt = S_RUN;
            w_pos_nxt   = '0;
            w_dir_nxt   = 1'b0;
            w_req_nxt   = w_start_req;
        end

        w_led_nxt = (w_state_nxt == S_RUN) ? (NLEDS'(1) << w_pos_nxt) : '0;
    end

    // Register read mux
    always_comb begin
        w_status = '0;
        w_status[STAT_BUSY_BIT] = r_busy;
        w_status[STAT_PEND_BIT] = r_pend;
        w_status[STAT_MODE_BIT] = r_req.mode;
        w_status[STAT_PASS_LSB +: PASS_W]    = r_req.passes;
        w_status[STAT_POS_LSB +: STAT_POS_W] = STAT_POS_W'(r_pos);

        w_rdata = '0;
        case (io_wb.i_wb_addr)
            ADDR_DIV:    w_rdata = WB_DW'(r_div);
            ADDR_STATUS: w_rdata = w_status;
            default:     w_rdata = '0;
        endcase
    end

    // Bus response and divider register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_ack   <= 1'b0;
            r_rdata <= '0;
            r_div   <= CW'(DEFAULT_DIV);
        end else begin
            r_ack   <= w_req;
            r_rdata <= (w_req && !io_wb.i_wb_we) ? w_rdata : '0;
            if (w_wr_div) begin
                r_div <= io_wb.i_wb_data[CW-1:0];
            end
        end
    end

    assign io_wb.o_wb_stall = 1'b0;
    assign io_wb.o_wb_ack   = r_ack;
    assign io_wb.o_wb_data  = r_rdata;
    assign o_led  = r_led;
    assign o_busy = r_busy;
    assign o_done = r_done;

endmodule

// File: tb/tb_ledwalker_wb.sv
// Scoreboard bench: stimulus queues expected acks, LED segments and busy windows; a monitor checks them.
module tb_ledwalker_wb;
    import ledwalker_pkg::*;

    localparam int unsigned NLEDS = 4;
    localparam int unsigned CW    = 8;
    localparam int unsigned DDIV  = 10;

    typedef struct {
        logic        rd;
        logic [1:0]  addr;
        logic [31:0] data;
    } ack_t;

    typedef struct {
        logic [NLEDS-1:0] val;
        int               lo;
        int               hi;
    } seg_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [NLEDS-1:0] led;
    logic             busy;
    logic             done;

    ledwalker_wb_if bus ();

    ledwalker_wb #(
        .NLEDS       (NLEDS),
        .CW          (CW),
        .DEFAULT_DIV (DDIV)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .io_wb   (bus),
        .o_led   (led),
        .o_busy  (busy),
        .o_done  (done)
    );

    always #5 clk = ~clk;

    int   n_chk = 0;
    int   n_err = 0;
    int   done_cnt = 0;
    ack_t exp_ack[$];
    seg_t exp_led[$];
    seg_t exp_busy[$];
    int   mid[5] = '{2, 4, 8, 4, 2};

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_rng(string name, int act, int lo, int hi);
        n_chk++;
        if (act < lo || act > hi) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d..%0d at %0t", name, act, lo, hi, $time);
        end
    endtask

    task automatic push_led(int v, int lo, int hi);
        seg_t s;
        s.val = NLEDS'(v);
        s.lo  = lo;
        s.hi  = hi;
        exp_led.push_back(s);
    endtask

    task automatic push_mid(int len);
        for (int i = 0; i < 5; i++) push_led(mid[i], len, len);
    endtask

    task automatic push_busy(int lo, int hi);
        seg_t s;
        s.val = '0;
        s.lo  = lo;
        s.hi  = hi;
        exp_busy.push_back(s);
    endtask

    task automatic wb_write(logic [1:0] a, logic [31:0] d);
        ack_t e;
        @(negedge clk);
        bus.i_wb_cyc  = 1'b1;
        bus.i_wb_stb  = 1'b1;
        bus.i_wb_we   = 1'b1;
        bus.i_wb_addr = a;
        bus.i_wb_data = d;
        e.rd = 1'b0; e.addr = a; e.data = '0;
        exp_ack.push_back(e);
        @(negedge clk);
        bus.i_wb_cyc = 1'b0;
        bus.i_wb_stb = 1'b0;
        bus.i_wb_we  = 1'b0;
    endtask

    task automatic wb_read(logic [1:0] a, logic [31:0] exp);
        ack_t e;
        @(negedge clk);
        bus.i_wb_cyc  = 1'b1;
        bus.i_wb_stb  = 1'b1;
        bus.i_wb_we   = 1'b0;
        bus.i_wb_addr = a;
        bus.i_wb_data = 32'hDEAD_BEEF;
        e.rd = 1'b1; e.addr = a; e.data = exp;
        exp_ack.push_back(e);
        @(negedge clk);
        bus.i_wb_cyc = 1'b0;
        bus.i_wb_stb = 1'b0;
    endtask

    task automatic wait_idle(int maxc);
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        chk("idle_timeout", 32'(busy), 32'h0);
    endtask

    // Checks acks, LED/busy run lengths and done pulses once per cycle, just after the edge
    task automatic monitor();
        logic [NLEDS-1:0] prev_led = '0;
        logic             prev_busy = 1'b0;
        int               led_len = 0;
        int               busy_len = 0;
        ack_t             a;
        seg_t             s;
        forever begin
            @(posedge clk);
            #1;
            chk("ack_latency", 32'(bus.o_wb_ack), 32'(bus.i_wb_cyc & bus.i_wb_stb));
            chk("stall", 32'(bus.o_wb_stall), 32'h0);
            if (bus.o_wb_ack) begin
                if (exp_ack.size() == 0) begin
                    chk("ack_unexpected", 32'(bus.o_wb_ack), 32'h0);
                end else begin
                    a = exp_ack.pop_front();
                    if (a.rd) chk($sformatf("rdata_addr%0d", a.addr), bus.o_wb_data, a.data);
                end
            end
            chk("led_vs_busy", 32'($onehot0(led) && ((led != '0) == busy)), 32'h1);
            if (done) begin
                done_cnt++;
                chk("done_edge", 32'({prev_busy, busy}), 32'h2);
            end
            if (led != prev_led) begin
                if (prev_led != '0) begin
                    if (exp_led.size() == 0) begin
                        chk("led_seg_extra", 32'(prev_led), 32'h0);
                    end else begin
                        s = exp_led.pop_front();
                        chk("led_seg_val", 32'(prev_led), 32'(s.val));
                        chk_rng("led_seg_len", led_len, s.lo, s.hi);
                    end
                end
                led_len = 1;
            end else begin
                led_len++;
            end
            if (busy != prev_busy) begin
                if (prev_busy) begin
                    if (exp_busy.size() == 0) begin
                        chk("busy_extra", 32'(busy_len), 32'h0);
                    end else begin
                        s = exp_busy.pop_front();
                        chk_rng("busy_len", busy_len, s.lo, s.hi);
                    end
                end
                busy_len = 1;
            end else begin
                busy_len++;
            end
            prev_led  = led;
            prev_busy = busy;
        end
    endtask

    task automatic stimulus();
        repeat (3) @(negedge clk);
        chk("rst_led", 32'(led), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_ack", 32'(bus.o_wb_ack), 32'h0);
        chk("rst_rdata", bus.o_wb_data, 32'h0);
        rst = 1'b0;

        wb_read(ADDR_DIV, 32'(DDIV));
        wb_read(ADDR_STATUS, 32'h0);
        wb_read(ADDR_CTRL, 32'h0);
        wb_write(ADDR_DIV, 32'hFFFF_FF02);
        wb_read(ADDR_DIV, 32'h2);

        // single bounce pass
        push_led(1, 3, 3); push_mid(3); push_led(1, 3, 3);
        push_busy(21, 21);
        wb_write(ADDR_CTRL, 32'h0100);
        wait_idle(100);
        repeat (2) @(negedge clk);
        chk("done_cnt_bounce", 32'(done_cnt), 32'd1);

        // wrap, two passes
        for (int p = 0; p < 2; p++) begin
            push_led(1, 3, 3); push_led(2, 3, 3); push_led(4, 3, 3); push_led(8, 3, 3);
        end
        push_busy(24, 24);
        wb_write(ADDR_CTRL, 32'h0201);
        wait_idle(100);
        repeat (2) @(negedge clk);
        chk("done_cnt_wrap", 32'(done_cnt), 32'd2);
        wb_read(ADDR_STATUS, 32'h0000_0004);

        // queued wrap behind a bounce, no idle gap
        push_led(1, 3, 3); push_mid(3); push_led(1, 6, 6);
        push_led(2, 3, 3); push_led(4, 3, 3); push_led(8, 3, 3);
        push_busy(33, 33);
        wb_write(ADDR_CTRL, 32'h0100);
        wb_write(ADDR_CTRL, 32'h0101);
        wb_read(ADDR_STATUS, 32'h0001_0103);
        wait_idle(100);
        repeat (2) @(negedge clk);
        chk("done_cnt_queue", 32'(done_cnt), 32'd3);

        // infinite bounce, pending request, then abort
        push_led(1, 3, 3); push_mid(3);
        repeat (4) begin
            push_led(1, 6, 6); push_mid(3);
        end
        push_led(1, 6, 6); push_led(2, 3, 3); push_led(4, 3, 3); push_led(8, 3, 3);
        push_led(4, 3, 3); push_led(2, 2, 2);
        push_busy(122, 122);
        wb_write(ADDR_CTRL, 32'h0000);
        repeat (50) @(negedge clk);
        wb_write(ADDR_CTRL, 32'h0101);
        repeat (68) @(negedge clk);
        wb_write(ADDR_ABORT, 32'h0);
        wb_read(ADDR_STATUS, 32'h0);
        repeat (5) @(negedge clk);
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_led", 32'(led), 32'h0);
        chk("done_cnt_abort", 32'(done_cnt), 32'd3);

        // DIV change mid-step
        push_led(1, 3, 3); push_led(2, 6, 6); push_led(4, 6, 6); push_led(8, 6, 6);
        push_busy(21, 21);
        wb_write(ADDR_CTRL, 32'h0101);
        wb_write(ADDR_DIV, 32'h5);
        wait_idle(100);
        repeat (2) @(negedge clk);
        chk("done_cnt_div", 32'(done_cnt), 32'd4);
        wb_read(ADDR_DIV, 32'h5);

        // asynchronous reset mid-walk
        push_led(1, 1, 1);
        push_busy(1, 1);
        wb_write(ADDR_CTRL, 32'h0100);
        #2 rst = 1'b1;
        #1;
        chk("arst_led", 32'(led), 32'h0);
        chk("arst_busy", 32'(busy), 32'h0);
        chk("arst_done", 32'(done), 32'h0);
        chk("arst_ack", 32'(bus.o_wb_ack), 32'h0);
        chk("arst_rdata", bus.o_wb_data, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wb_read(ADDR_DIV, 32'(DDIV));
        wb_read(ADDR_STATUS, 32'h0);
        repeat (3) @(negedge clk);
        chk("done_cnt_final", 32'(done_cnt), 32'd4);

        chk("ack_queue_left", 32'(exp_ack.size()), 32'h0);
        chk("led_queue_left", 32'(exp_led.size()), 32'h0);
        chk("busy_queue_left", 32'(exp_busy.size()), 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        bus.i_wb_cyc  = 1'b0;
        bus.i_wb_stb  = 1'b0;
        bus.i_wb_we   = 1'b0;
        bus.i_wb_addr = '0;
        bus.i_wb_data = '0;
        fork
            monitor();
            stimulus();
        join_any
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
